bitwise_reduce_unit: RTL and testbench
======================================

# bitwise_reduce_unit

- Parametrised, clocked successor to the two-input AND primitive.
- Folds a framed stream of WIDTH-bit operands into one result using a selectable bitwise operator: AND, OR, XOR or NAND.
- Sits between a valid/ready producer and consumer; one result per frame, registered output.
- Reports beat count and overflow alongside the result.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- MAX_LEN, 16, maximum beats per frame before overflow is flagged (≥2)
- LEN_W, $clog2(MAX_LEN+1), width of the beat counter (derived, not overridden)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- op  input  2  operator: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first beat of frame
- in_valid  input  1  producer has a beat
- in_ready  output  1  unit accepts a beat this cycle
- in_data  input  WIDTH  operand
- in_last  input  1  beat is the final one of its frame
- out_valid  output  1  result held for consumer
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  reduced result
- out_count  output  LEN_W  beats folded, saturating at MAX_LEN
- out_overflow  output  1  frame had more than MAX_LEN beats

## Operation
- States: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
- A beat transfers when in_valid && in_ready; in_ready = (state != HOLD), combinational from state only.
- IDLE + transfer:
  - acc ← in_data; count ← 1; op_q ← op.
  - in_last=1 → HOLD; else → ACCUM.
- ACCUM + transfer:
  - acc ← acc OP in_data; NAND accumulates as AND.
  - count ← count+1, saturating at MAX_LEN.
  - If count already = MAX_LEN, ovf ← 1.
  - in_last=1 → HOLD.
- Entering HOLD:
  - out_data ← final acc, bitwise inverted when op_q=NAND.
  - out_count ← count; out_overflow ← ovf.
- HOLD: outputs stable until out_valid && out_ready, then → IDLE; acc, count and ovf clear.
- op changes while in ACCUM or HOLD are ignored; op_q governs the whole frame.
- Single-beat frame: out_data = in_data (NAND: ~in_data), out_count = 1.
- Overflow beats are still folded into acc; only the counter saturates.
- in_valid=0 cycles inside a frame hold all state; no timeout.

## Timing
- Reset values: out_valid 0, out_data 0, out_count 0, out_overflow 0, state IDLE, therefore in_ready 1.
- Latency: out_valid rises the cycle after the last beat transfers.
- Throughput: an N-beat frame occupies ≥N+1 cycles; the next frame's first beat is accepted no earlier than the cycle after the result handshake.
- out_ready held high: HOLD lasts exactly one cycle.
- in_valid && in_last in the same cycle as the output handshake: not possible (in_ready=0 in HOLD); the beat is held by the producer.
- rst_n low mid-frame or in HOLD:
  - Partial frame and pending result are discarded.
  - Outputs take reset values immediately (asynchronous).
  - Operation resumes in IDLE on the first clk edge after deassertion.
- No combinational path from in_* to out_*.

## Structure
- Shared package bitwise_pkg holds the op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND) and the state encodings (IDLE, ACCUM, HOLD).
- One sub-module, bitwise_op_alu: combinational, parameter WIDTH, inputs a, b, op; output a OP b. NAND maps to AND inside the ALU; the final inversion stays in the parent.
- Parent holds the FSM, counter, accumulator and output registers.

## Test plan
- WIDTH=8, AND, frame 0xFF,0xF0,0x3C (last) → out_data 0x30, out_count 3, out_overflow 0, out_valid one cycle after the last beat.
- XOR single-beat frame 0xA5 (last), out_ready=0 for 4 cycles → out_data 0xA5 stable, out_count 1, in_ready 0 throughout HOLD; returns to IDLE after the handshake.
- NAND frame 0xCC,0xAA (last); op switched to OR after the first beat → out_data 0x77 (op switch ignored).
- MAX_LEN=16, OR frame of 18 beats, each 0x01<<(i%8) → out_data 0xFF, out_count 16, out_overflow 1.
- OR frame 0x0F,0x30 with in_valid gaps between beats, then rst_n pulsed low mid-next-frame → first result 0x3F; after reset all outputs 0, in_ready 1; a fresh frame 0x81 (last) gives 0x81, count 1.

Source files
------------

// File: rtl/bitwise_pkg.sv
// Shared encodings for the bitwise reduction unit: operator select and FSM states.
package bitwise_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/bitwise_op_alu.sv
// Combinational two-operand bitwise operator; NAND folds as AND, the parent applies the final inversion.
module bitwise_op_alu
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a & b;
        case (op)
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/bitwise_reduce_unit.sv
// Folds a framed valid/ready stream into one registered result per frame, with beat count and overflow.
module bitwise_reduce_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LEN_W-1:0] out_count,
    output logic             out_overflow
);

    state_e           state_q, state_d;
    op_e              op_q, op_eff;
    logic [WIDTH-1:0] acc_q, acc_d, alu_y;
    logic [LEN_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             take, done;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
        if (c == LEN_W'(MAX_LEN)) return c;
        return c + LEN_W'(1);
    endfunction

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign take      = in_valid && in_ready;
    assign done      = out_valid && out_ready;
    // The first beat of a frame uses the live op; later beats use the latched one.
    assign op_eff    = (state_q == IDLE) ? op_e'(op) : op_q;

    bitwise_op_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (acc_q),
        .b  (in_data),
        .op (op_q),
        .y  (alu_y)
    );

    always_comb begin
        acc_d   = alu_y;
        count_d = sat_inc(count_q);
        ovf_d   = ovf_q;
        if (state_q == IDLE) begin
            acc_d   = in_data;
            count_d = LEN_W'(1);
            ovf_d   = 1'b0;
        end else if (count_q == LEN_W'(MAX_LEN)) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = in_last ? HOLD : ACCUM;
            ACCUM:   if (take && in_last) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_AND;
            acc_q        <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            out_data     <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                acc_q   <= acc_d;
                count_q <= count_d;
                ovf_q   <= ovf_d;
                if (state_q == IDLE) op_q <= op_e'(op);
                if (in_last) begin
                    out_data     <= (op_eff == OP_NAND) ? ~acc_d : acc_d;
                    out_count    <= count_d;
                    out_overflow <= ovf_d;
                end
            end
            if (done) begin
                acc_q   <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_reduce_unit.sv
// Directed and randomized checks of bitwise_reduce_unit against a queue-based fold model.
module tb_bitwise_reduce_unit;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LEN_W-1:0] out_count;
    logic             out_overflow;

    int total = 0;
    int bad   = 0;

    bitwise_reduce_unit #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: fold the whole frame with the frame's operator, NAND = inverted AND-fold.
    function automatic logic [7:0] fold(input logic [1:0] o, input logic [7:0] q[$]);
        logic [7:0] r;
        r = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (o == 2'd1)      r = r | q[i];
            else if (o == 2'd2) r = r ^ q[i];
            else                r = r & q[i];
        end
        if (o == 2'd3) r = ~r;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic [1:0] o);
        int n = 0;
        in_data = d; in_last = last; op = o; in_valid = 1'b1;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!in_ready) check("beat_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [7:0] ed, input int ec, input logic eo);
        int n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data), 32'(ed));
        check({tag, "_count"}, 32'(out_count), 32'(ec));
        check({tag, "_ovf"},   32'(out_overflow), 32'(eo));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [1:0] fo;
        int         len;

        rst_n = 1'b0; op = 2'd0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf",   32'(out_overflow), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);

        // AND frame with latency check
        beat(8'hFF, 1'b0, 2'd0);
        beat(8'hF0, 1'b0, 2'd0);
        check("and_not_yet_valid", 32'(out_valid), 32'd0);
        beat(8'h3C, 1'b1, 2'd0);
        check("and_latency", 32'(out_valid), 32'd1);
        collect("and", 8'h30, 3, 1'b0);

        // XOR single beat, consumer stalls for 4 cycles
        beat(8'hA5, 1'b1, 2'd2);
        for (int i = 0; i < 4; i++) begin
            check("xor_hold_data",  32'(out_data), 32'hA5);
            check("xor_hold_ready", 32'(in_ready), 32'd0);
            check("xor_hold_valid", 32'(out_valid), 32'd1);
            step(1);
        end
        collect("xor", 8'hA5, 1, 1'b0);

        // NAND frame, op switched mid-frame
        beat(8'hCC, 1'b0, 2'd3);
        beat(8'hAA, 1'b1, 2'd1);
        collect("nand", 8'h77, 2, 1'b0);

        // Overflow frame with out_ready held high: HOLD lasts one cycle
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) beat(8'h01 << (i % 8), 1'(i == 17), 2'd1);
        check("ovf_valid", 32'(out_valid), 32'd1);
        check("ovf_data",  32'(out_data), 32'hFF);
        check("ovf_count", 32'(out_count), 32'd16);
        check("ovf_flag",  32'(out_overflow), 32'd1);
        step(1);
        check("ovf_one_cycle", 32'(out_valid), 32'd0);
        check("ovf_in_ready",  32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // OR frame with gaps, then reset mid-frame
        beat(8'h0F, 1'b0, 2'd1);
        step(3);
        beat(8'h30, 1'b1, 2'd1);
        collect("or_gap", 8'h3F, 2, 1'b0);
        beat(8'h55, 1'b0, 2'd1);
        beat(8'h66, 1'b0, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data), 32'd0);
        check("mid_rst_count", 32'(out_count), 32'd0);
        check("mid_rst_ovf",   32'(out_overflow), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        step(1);
        beat(8'h81, 1'b1, 2'd0);
        collect("post_rst", 8'h81, 1, 1'b0);

        // Randomized frames; op wiggles on non-first beats and must be ignored
        for (int f = 0; f < 25; f++) begin
            fo  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 20);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            for (int i = 0; i < len; i++) begin
                beat(q[i], 1'(i == len - 1), (i == 0) ? fo : 2'($urandom_range(0, 3)));
                if (i != len - 1) step($urandom_range(0, 2));
            end
            step($urandom_range(0, 3));
            collect("rand", fold(fo, q), (len > MAX_LEN) ? MAX_LEN : len, 1'(len > MAX_LEN));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
